// File: rtl/dcache_arbiter_if.sv
// Two-port request/response bus between the cache requesters and dcache_arbiter.
// The arbiter takes the slave view; the requesters take the master view.
interface dcache_arbiter_if #(
  parameter int AW = 4
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [7:0]    wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [7:0]    rdata;
  logic          err;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, err
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, err
  );
endinterface

// File: rtl/dcache_arbiter.sv
// Round-robin arbiter granting two requesters access to a small single-ported
// byte memory; each access runs IDLE -> GRANT -> RESP.
module dcache_arbiter #(
  parameter int DEPTH = 11,
  parameter int AW    = 4
) (
  input logic             clk,
  input logic             rst_n,
  dcache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RESP
  } state_t;

  state_t        state, next_state;
  logic          winner;
  logic          last_winner;
  logic          l_win;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [7:0]    l_wdata;
  logic [7:0]    rdata_q;
  logic          in_range;
  logic          any_req;
  logic [7:0]    mem [DEPTH];

  assign any_req   = bus.req0 | bus.req1;
  assign in_range  = (32'(l_addr) < DEPTH);
  assign bus.rdata = rdata_q;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    winner = bus.req1;
    if (bus.req0 && bus.req1) begin
      winner = ~last_winner;
    end
  end

  always_comb begin
    next_state  = state;
    bus.gnt0    = 1'b0;
    bus.gnt1    = 1'b0;
    bus.rvalid0 = 1'b0;
    bus.rvalid1 = 1'b0;
    bus.err     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          next_state = GRANT;
        end
      end
      GRANT: begin
        next_state = RESP;
        bus.gnt0   = ~l_win;
        bus.gnt1   = l_win;
        bus.err    = ~in_range;
      end
      RESP: begin
        next_state  = IDLE;
        bus.rvalid0 = ~l_we & ~l_win;
        bus.rvalid1 = ~l_we & l_win;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the winning request so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner <= 1'b1;
      l_win       <= 1'b0;
      l_we        <= 1'b0;
      l_addr      <= '0;
      l_wdata     <= '0;
    end else if (state == IDLE && any_req) begin
      last_winner <= winner;
      l_win       <= winner;
      l_we        <= winner ? bus.we1 : bus.we0;
      l_addr      <= winner ? bus.addr1 : bus.addr0;
      l_wdata     <= winner ? bus.wdata1 : bus.wdata0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      rdata_q <= 8'h00;
    end else if (state == GRANT) begin
      if (l_we && in_range) begin
        mem[l_addr] <= l_wdata;
      end
      if (!l_we) begin
        rdata_q <= in_range ? mem[l_addr] : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_dcache_arbiter.sv
// Directed bench for dcache_arbiter: hand-computed vectors checked against a
// small byte-memory model kept by the bench.
module tb_dcache_arbiter;

  localparam int DEPTH = 11;
  localparam int AW    = 4;

  logic clk;
  logic rst_n;
  int   total_count;
  int   bad_count;
  logic [7:0] model [16];
  logic [7:0] last_rdata;

  dcache_arbiter_if #(.AW(AW)) bus ();

  dcache_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_count++;
    if (got !== exp) begin
      bad_count++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One complete access from a single port; inputs are scrambled during GRANT.
  task automatic applyStimulus(input int p, input logic we, input logic [AW-1:0] addr,
                               input logic [7:0] wdata, input string tag);
    logic       bad_addr;
    logic [7:0] exp_rdata;
    bad_addr  = (int'(addr) >= DEPTH);
    exp_rdata = bad_addr ? 8'h00 : model[addr];
    @(negedge clk);
    checkOutput({tag, "_idle_gnt"}, {30'd0, bus.gnt0, bus.gnt1}, 32'd0);
    checkOutput({tag, "_idle_rdata"}, {24'd0, bus.rdata}, {24'd0, last_rdata});
    if (p == 0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end
    @(negedge clk);
    checkOutput({tag, "_gnt"}, {30'd0, bus.gnt0, bus.gnt1}, (p == 0) ? 32'd2 : 32'd1);
    checkOutput({tag, "_err"}, {31'd0, bus.err}, {31'd0, bad_addr});
    checkOutput({tag, "_gnt_rvalid"}, {30'd0, bus.rvalid0, bus.rvalid1}, 32'd0);
    if (p == 0) begin
      bus.req0 = 1'b0; bus.we0 = ~we; bus.addr0 = addr ^ 4'h7; bus.wdata0 = ~wdata;
    end else begin
      bus.req1 = 1'b0; bus.we1 = ~we; bus.addr1 = addr ^ 4'h7; bus.wdata1 = ~wdata;
    end
    @(negedge clk);
    checkOutput({tag, "_resp_gnt_err"}, {29'd0, bus.gnt0, bus.gnt1, bus.err}, 32'd0);
    if (we) begin
      checkOutput({tag, "_wr_rvalid"}, {30'd0, bus.rvalid0, bus.rvalid1}, 32'd0);
      checkOutput({tag, "_wr_rdata_hold"}, {24'd0, bus.rdata}, {24'd0, last_rdata});
      if (!bad_addr) model[addr] = wdata;
    end else begin
      checkOutput({tag, "_rd_rvalid"}, {30'd0, bus.rvalid0, bus.rvalid1},
                  (p == 0) ? 32'd2 : 32'd1);
      checkOutput({tag, "_rd_rdata"}, {24'd0, bus.rdata}, {24'd0, exp_rdata});
      last_rdata = exp_rdata;
    end
  endtask

  task automatic dumpMemory(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(i % 2, 1'b0, AW'(i), 8'h00, $sformatf("%s_%0d", tag, i));
    end
  endtask

  initial begin
    total_count = 0;
    bad_count   = 0;
    last_rdata  = 8'h00;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_pulses", {27'd0, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err}, 32'd0);
    checkOutput("reset_rdata", {24'd0, bus.rdata}, 32'd0);
    rst_n = 1'b1;

    // Continuous tie: grants every third cycle, alternating starting with port 0.
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checkOutput($sformatf("tie_gnt_c%0d", k), {30'd0, bus.gnt0, bus.gnt1},
                  (k % 3 == 1) ? (((k / 3) % 2 == 0) ? 32'd2 : 32'd1) : 32'd0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    applyStimulus(0, 1'b1, 4'd3, 8'h5A, "p0_wr3");
    applyStimulus(0, 1'b0, 4'd3, 8'h00, "p0_rd3");
    applyStimulus(1, 1'b1, 4'd10, 8'hFF, "p1_wr10");
    applyStimulus(0, 1'b0, 4'd10, 8'h00, "p0_rd10");
    applyStimulus(1, 1'b1, 4'd12, 8'h11, "p1_wr12_oor");
    applyStimulus(1, 1'b0, 4'd12, 8'h00, "p1_rd12_oor");
    dumpMemory("dump_a");

    applyStimulus(0, 1'b1, 4'd2, 8'h22, "p0_wr2");
    applyStimulus(0, 1'b1, 4'd5, 8'h55, "p0_wr5");
    applyStimulus(0, 1'b0, 4'd2, 8'h00, "p0_rd2_scrambled");
    applyStimulus(1, 1'b0, 4'd5, 8'h00, "p1_rd5");

    // Reset during GRANT of a write must leave memory untouched.
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd0; bus.wdata0 = 8'h77;
    @(negedge clk);
    checkOutput("rst_mid_gnt_before", {30'd0, bus.gnt0, bus.gnt1}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_pulses", {27'd0, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err}, 32'd0);
    checkOutput("rst_mid_rdata", {24'd0, bus.rdata}, 32'd0);
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    last_rdata = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.addr0 = 4'd5; bus.addr1 = 4'd5;
    @(negedge clk);
    checkOutput("post_rst_tie_gnt", {30'd0, bus.gnt0, bus.gnt1}, 32'd2);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_tie_rvalid", {30'd0, bus.rvalid0, bus.rvalid1}, 32'd2);
    checkOutput("post_rst_tie_rdata", {24'd0, bus.rdata}, 32'd0);
    dumpMemory("dump_b");

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule

// File: doc/dcache_arbiter.md
DCACHE_ARBITER -- requirements
Module: dcache_arbiter

Interface
REQ-001 Parameter DEPTH, default 11, SHALL set the number of 8-bit data-memory entries.
REQ-002 Parameter AW, default 4, SHALL set the address width; DEPTH SHALL be at most 2**AW.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req0 / req1  input  1  SHALL be the access request from port 0 (core load/store) / port 1 (host loader).
REQ-006 we0 / we1  input  1  SHALL select the access type: 1 = write, 0 = read.
REQ-007 addr0 / addr1  input  AW  SHALL be the byte address.
REQ-008 wdata0 / wdata1  input  8  SHALL be the write data.
REQ-009 gnt0 / gnt1  output  1  SHALL be the registered grant, pulsed for one cycle.
REQ-010 rvalid0 / rvalid1  output  1  SHALL be the registered read-data-valid pulse.
REQ-011 rdata  output  8  SHALL be the read data, shared by both ports and qualified by rvalid0/rvalid1.
REQ-012 err  output  1  SHALL be a one-cycle pulse flagging an out-of-range access, issued alongside the grant.

Function
REQ-013 Storage SHALL be DEPTH x 8-bit, single-ported, with at most one access per memory cycle.
REQ-014 The FSM SHALL have exactly three states: IDLE, GRANT, RESP.
REQ-015 In IDLE with no request pending, the FSM SHALL stay in IDLE and all pulse outputs SHALL be 0.
REQ-016 In IDLE with a request pending, the FSM SHALL latch the winner's index, we, addr and wdata on the edge, then enter GRANT.
REQ-017 Arbitration with only one request SHALL grant that port.
REQ-018 Arbitration with both requests SHALL grant the port that is not last_winner (round-robin).
REQ-019 last_winner SHALL update to the granted port on every grant.
REQ-020 In GRANT, gnt of the winning port SHALL be 1 and the other gnt SHALL be 0.
REQ-021 In GRANT, the memory access SHALL use the latched fields and complete on the closing edge; the FSM then enters RESP.
REQ-022 In RESP, for a read, rvalid of the winner SHALL be 1 and rdata SHALL equal mem[addr] as sampled in GRANT.
REQ-023 In RESP, for a write, both rvalid outputs SHALL stay 0; RESP SHALL always return to IDLE after one cycle.
REQ-024 Latency SHALL be: request sampled in IDLE at cycle T, gnt at T+1, rvalid at T+2; peak throughput one access per 3 cycles.
REQ-025 Requests SHALL be level-sensitive; a requester SHALL drop req in the cycle after gnt, otherwise the request is re-arbitrated as a new access in the next IDLE.
REQ-026 Input changes during GRANT/RESP SHALL NOT affect the in-flight access.
REQ-027 If the latched addr >= DEPTH, err SHALL pulse during GRANT, a write SHALL be discarded, and a read SHALL return rdata = 0 with rvalid still asserted.
REQ-028 rdata SHALL hold its last value outside RESP.
REQ-029 A write from one port followed by a read of the same address from either port SHALL return the new data (no stale read).

Reset
REQ-030 When rst_n = 0, the block SHALL immediately, regardless of clk, go to IDLE.
REQ-031 When rst_n = 0, last_winner SHALL be 1, so port 0 wins the first tie.
REQ-032 When rst_n = 0, gnt0, gnt1, rvalid0, rvalid1 and err SHALL be 0 and rdata SHALL be 0x00.
REQ-033 When rst_n = 0, all memory entries SHALL be 0x00.
REQ-034 Reset asserted during GRANT SHALL abort the access; a pending write SHALL NOT reach memory if reset arrives before its commit edge.
REQ-035 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge that samples rst_n = 1.

Verification
REQ-036 Single write/read: port0 writes 0x5A to addr 3, then reads addr 3 -> gnt0 at T+1, rvalid0 at T+2 with rdata = 0x5A, rvalid1 never set.
REQ-037 Tie after reset: req0 = req1 = 1 held continuously -> grants alternate 0,1,0,1 at intervals of 3 cycles; no port receives two consecutive grants.
REQ-038 Cross-port coherence: port1 writes 0xFF to addr 10, then port0 reads addr 10 -> rdata = 0xFF.
REQ-039 Out of range: port1 writes 0x11 to addr 12, then reads addr 12 -> err pulses with each gnt1, read returns 0x00, and a full memory dump is unchanged.
REQ-040 Reset mid-access: rst_n pulled low during GRANT of a write of 0x77 to addr 0 -> outputs 0 immediately, mem[0] = 0x00, and the next tie grants port 0.
REQ-041 Input stability: addr0 changed from 2 to 5 during GRANT of a read -> rdata returns mem[2].
